// File: rtl/resample18v_engine_pkg.sv
// Shared constants, state encoding and helper functions for the resample18v
// polyphase resampler.
//   TAPS/PHASES : fixed by the 1024 x 18 coefficient ROM (64 taps x 16 phases)
//   ACCW        : accumulator width (36-bit product + 6 growth bits)
//   SHIFT_DEF   : default number of accumulator LSBs dropped before rounding
package resample18v_pkg;
  localparam int TAPS      = 64;
  localparam int PHASES    = 16;
  localparam int ACCW      = 42;
  localparam int SHIFT_DEF = 17;
  localparam int DW        = 18;            // sample / coefficient width
  localparam int AW        = 10;            // ROM address width
  localparam int SW        = 20;            // step width
  localparam int HALF      = TAPS / 2;      // taps per ROM port per output
  localparam int KW        = 5;             // tap-pair counter width
  localparam int PW        = 4;             // phase index width
  localparam int HW        = 6;             // history address width

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic signed [ACCW:0] SAT_HI = {{(ACCW+1-DW){1'b0}}, 18'h1FFFF};
  localparam logic signed [ACCW:0] SAT_LO = {{(ACCW+1-DW){1'b1}}, 18'h20000};

  // ROM layout: top bit selects the tap half (port A = taps 0..31,
  // port B = taps 32..63), then the tap-pair index, then the phase.
  function automatic logic [AW-1:0] rom_addr(input logic half,
                                              input logic [KW-1:0] k,
                                              input logic [PW-1:0] ph);
    return {half, k, ph};
  endfunction

  // Round half up after dropping sh LSBs, then clip to signed 18 bits.
  function automatic logic [DW-1:0] sat_round(input logic signed [ACCW-1:0] acc,
                                              input int sh);
    logic signed [ACCW:0] ext, bias, r;
    ext  = {acc[ACCW-1], acc};
    bias = (ACCW+1)'(1) << (sh - 1);
    r    = (ext + bias) >>> sh;
    if (r > SAT_HI)      return 18'h1FFFF;
    else if (r < SAT_LO) return 18'h20000;
    else                 return r[DW-1:0];
  endfunction
endpackage

// File: rtl/resample18v_engine_if.sv
// Bundle of the engine's streaming and ROM signals.
//   slave  : engine side (consumes din/step/ROM data, produces dout/ROM addresses)
//   master : environment side (source, sink and ROM)
interface resample18v_if;
  import resample18v_pkg::*;
  logic          ce;
  logic [SW-1:0] step;
  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic [AW-1:0] rom_aa;
  logic [AW-1:0] rom_ab;
  logic [DW-1:0] rom_da;
  logic [DW-1:0] rom_db;
  logic          rom_ce;

  modport slave (
    input  ce, step, din, din_vld, dout_rdy, rom_da, rom_db,
    output din_rdy, dout, dout_vld, rom_aa, rom_ab, rom_ce
  );
  modport master (
    output ce, step, din, din_vld, dout_rdy, rom_da, rom_db,
    input  din_rdy, dout, dout_vld, rom_aa, rom_ab, rom_ce
  );
endinterface

// File: rtl/resample18v_engine_hist.sv
// 64 x 18 sample history: one synchronous write port, two asynchronous read
// lanes (one per ROM port). Contents are deliberately not reset.
//   we_i/wa_i/wd_i : write enable, address, data
//   ra_i[l]/rd_o[l]: read address / data for lane l
module resample18v_hist
  import resample18v_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [HW-1:0]      wa_i,
  input  logic [DW-1:0]      wd_i,
  input  logic [1:0][HW-1:0] ra_i,
  output logic [1:0][DW-1:0] rd_o
);
  logic [DW-1:0] mem_q [TAPS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign rd_o[g] = mem_q[ra_i[g]];
  end
endmodule

// File: rtl/resample18v_engine.sv
// Polyphase fractional resampler. Collects input samples into a 64-deep
// history, then for each output walks the 64 taps of phase mu[15:12], two
// per cycle through the dual-port coefficient ROM, and emits one rounded,
// saturated sample.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : streaming in/out handshakes, step, clock enable, ROM port
module resample18v_engine
  import resample18v_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  resample18v_if.slave bus
);
  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q;
  logic [1:0]               drn_q;
  logic [15:0]              mu_q;
  logic [6:0]               need_q;
  logic [HW-1:0]            wp_q;
  // [0]: ROM data valid, [1]: products valid
  logic [1:0]               vld_pipe_q, fst_pipe_q;
  logic [1:0][HW-1:0]       hra;
  logic [1:0][DW-1:0]       hrd;
  logic signed [DW-1:0]     ha_q, hb_q;
  logic signed [2*DW-1:0]   pa_q, pb_q;
  logic signed [ACCW-1:0]   acc_q, acc_base;
  logic [DW-1:0]            dout_q;
  logic                     dout_vld_q;
  logic                     issue, din_acc, out_load, out_hs;
  logic [20:0]              sum;

  assign sum      = {5'd0, mu_q} + {1'b0, bus.step};
  assign issue    = (state_q == ST_CALC);
  assign din_acc  = (state_q == ST_WAIT) && (need_q != '0) && bus.din_vld;
  assign out_load = (state_q == ST_OUT) && !dout_vld_q;
  assign out_hs   = (state_q == ST_OUT) && dout_vld_q && bus.dout_rdy;
  assign acc_base = fst_pipe_q[1] ? '0 : acc_q;

  // Port A pairs with the newest 32 samples, port B with the older 32.
  assign hra[0] = wp_q - HW'(1)  - HW'(k_q);
  assign hra[1] = wp_q - HW'(33) - HW'(k_q);

  resample18v_hist u_hist (
    .clk  (clk),
    .we_i (bus.ce && din_acc),
    .wa_i (wp_q),
    .wd_i (bus.din),
    .ra_i (hra),
    .rd_o (hrd)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state_q <= ST_WAIT;
    else if (bus.ce) state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT:  if (need_q == '0) state_d = ST_CALC;
      ST_CALC:  if (k_q == KW'(HALF - 1)) state_d = ST_DRAIN;
      ST_DRAIN: if (drn_q == 2'd2) state_d = ST_OUT;
      ST_OUT:   if (out_hs) state_d = (sum[20:16] != '0) ? ST_WAIT : ST_CALC;
      default:  state_d = ST_WAIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.din_rdy  = (state_q == ST_WAIT) && (need_q != '0);
    bus.rom_aa   = rom_addr(1'b0, k_q, mu_q[15:12]);
    bus.rom_ab   = rom_addr(1'b1, k_q, mu_q[15:12]);
    bus.rom_ce   = bus.ce;
    bus.dout     = dout_q;
    bus.dout_vld = dout_vld_q;
  end

  // Counters and phase/rate bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      drn_q  <= '0;
      mu_q   <= '0;
      need_q <= 7'd64;
      wp_q   <= '0;
    end else if (bus.ce) begin
      k_q   <= issue ? k_q + 1'b1 : '0;
      drn_q <= (state_q == ST_DRAIN) ? drn_q + 1'b1 : '0;
      if (din_acc) begin
        wp_q   <= wp_q + 1'b1;
        need_q <= need_q - 1'b1;
      end else if (out_hs) begin
        // step is only looked at here, so it may change freely otherwise
        mu_q   <= sum[15:0];
        need_q <= {2'b00, sum[20:16]};
      end
    end
  end

  // MAC pipeline: issue -> ROM/history regs -> products -> accumulate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      fst_pipe_q <= '0;
      ha_q       <= '0;
      hb_q       <= '0;
      pa_q       <= '0;
      pb_q       <= '0;
      acc_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (bus.ce) begin
      vld_pipe_q <= {vld_pipe_q[0], issue};
      fst_pipe_q <= {fst_pipe_q[0], issue && (k_q == '0)};
      // history is registered alongside the ROM so both reach the multiplier together
      ha_q <= hrd[0];
      hb_q <= hrd[1];
      if (vld_pipe_q[0]) begin
        pa_q <= ha_q * $signed(bus.rom_da);
        pb_q <= hb_q * $signed(bus.rom_db);
      end
      if (vld_pipe_q[1]) acc_q <= acc_base + ACCW'(pa_q) + ACCW'(pb_q);
      if (out_load) begin
        dout_q     <= sat_round(acc_q, SHIFT);
        dout_vld_q <= 1'b1;
      end else if (out_hs) begin
        dout_vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_resample18v_engine.sv
module tb_resample18v_engine;
  import resample18v_pkg::*;
  localparam int SH = 16;

  logic clk = 1'b0;
  logic rst;
  resample18v_if bus();

  resample18v_engine #(.SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Coefficient ROM, one-cycle latency, frozen by rom_ce
  logic [17:0] rom [1024];
  always_ff @(posedge clk) begin
    if (bus.rom_ce) begin
      bus.rom_da <= rom[bus.rom_aa];
      bus.rom_db <= rom[bus.rom_ab];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [17:0] hq[$];     // accepted samples, newest first
  int unsigned mu_m, need_m, nacc, s_m;
  int n_out = 0;
  int cyc = 0;
  int last_acc_cyc = 0, rise_cyc = 0;
  logic prev_vld = 1'b0;
  logic [17:0] last_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // y = sum over taps j of coef(phase, j) * x[n-j]; taps 0..31 live in the
  // lower ROM half, taps 32..63 in the upper half, phase in the low bits.
  function automatic logic [17:0] ref_out(input int ph);
    longint s, q;
    s = 0;
    for (int j = 0; j < 64; j++)
      s += longint'($signed(rom[ph + 16 * (j % 32) + 512 * (j / 32)])) * longint'(hq[j]);
    q = (s + (longint'(1) <<< (SH - 1))) >>> SH;
    if (q > 131071)  return 18'h1FFFF;
    if (q < -131072) return 18'h20000;
    return 18'(q);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mu_m = 0; need_m = 64; nacc = 0; prev_vld = 1'b0;
    end else begin
      if (bus.ce && bus.din_vld && bus.din_rdy) begin
        hq.push_front(bus.din);
        if (hq.size() > 64) hq.delete(64);
        nacc++;
        last_acc_cyc = cyc;
      end
      if (bus.dout_vld && !prev_vld) rise_cyc = cyc;
      prev_vld = bus.dout_vld;
      if (bus.ce && bus.dout_vld && bus.dout_rdy) begin
        chk("dout", 32'(bus.dout), 32'(ref_out(int'(mu_m >> 12))));
        chk("nin", nacc, need_m);
        chk("phase", 32'(bus.rom_aa[3:0]), mu_m >> 12);
        last_dout = bus.dout;
        s_m    = mu_m + 32'(bus.step);
        mu_m   = s_m & 32'hFFFF;
        need_m = s_m >> 16;
        nacc   = 0;
        n_out++;
      end
    end
  end

  // ---------------- stimulus driver ----------------
  logic in_rand = 1'b1, in_const = 1'b0, rdy_rand = 1'b1, rdy_hold = 1'b0;
  logic [17:0] cval = '0;

  initial begin
    bus.din_vld = 1'b0; bus.din = '0; bus.dout_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.din_vld  = in_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.din      = in_const ? cval : 18'($urandom);
      bus.dout_rdy = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  task automatic wait_outs(input int n, input int budget);
    int target, t;
    target = n_out + n; t = 0;
    while (n_out < target && t < budget) begin @(posedge clk); t++; end
    chk("outs_done", 32'(n_out >= target), 1);
  endtask

  task automatic wait_vld(input int budget);
    int t; t = 0;
    while (!bus.dout_vld && t < budget) begin @(negedge clk); t++; end
    #1;
    chk("vld_seen", 32'(bus.dout_vld), 1);
  endtask

  task automatic wait_primed(input int budget);
    int t; t = 0;
    @(negedge clk);
    while (bus.din_rdy && t < budget) begin @(negedge clk); t++; end
    chk("primed", 32'(bus.din_rdy), 0);
  endtask

  task automatic hold_rst();
    @(posedge clk); #2; rst = 1'b0;
  endtask

  task automatic rel_rst();
    @(posedge clk); @(posedge clk); #2; rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [17:0] d0;
    rst = 1'b0; bus.ce = 1'b1; bus.step = 20'h10000;
    // identity ROM: 2^16 at tap 0 of phase 0
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0] = 18'h10000;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdy", 32'(bus.din_rdy), 1);
    chk("rst_vld", 32'(bus.dout_vld), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    rst = 1'b1;

    // identity, then rate control
    wait_outs(6, 3000);
    in_const = 1'b1; cval = 18'h00123;
    wait_outs(2, 400);
    chk("ident_ex", 32'(last_dout), 32'h00123);
    in_const = 1'b0;
    #1 bus.step = 20'h20000;
    wait_outs(4, 800);
    #1 bus.step = 20'h04000;
    wait_outs(8, 1200);

    // random coefficients, random step per output
    hold_rst();
    for (int i = 0; i < 1024; i++) rom[i] = 18'($urandom);
    rel_rst();
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0: bus.step = 20'h10000;
        1: bus.step = 20'h20000;
        2: bus.step = 20'h04000;
        3: bus.step = 20'h00000;
        4: bus.step = 20'hFFFFF;
        default: bus.step = 20'($urandom_range(0, 20'hFFFFF));
      endcase
      wait_outs(1, 600);
      #1;
    end

    // saturation
    bus.step = 20'h10000;
    in_rand = 1'b0; in_const = 1'b1; cval = 18'h1FFFF;
    hold_rst();
    for (int i = 0; i < 1024; i++) rom[i] = 18'h1FFFF;
    rel_rst();
    wait_outs(1, 400);
    chk("sat_pos", 32'(last_dout), 32'h1FFFF);
    cval = 18'h20000;
    hold_rst(); rel_rst();
    wait_outs(1, 400);
    chk("sat_neg", 32'(last_dout), 32'h20000);

    // priming latency and backpressure
    in_const = 1'b0;
    hold_rst();
    for (int i = 0; i < 1024; i++) rom[i] = 18'($urandom);
    rdy_hold = 1'b1;
    rel_rst();
    wait_vld(400);
    chk("prime_lat", rise_cyc - last_acc_cyc, 38);
    @(negedge clk);
    d0 = bus.dout;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_dout", 32'(bus.dout), 32'(d0));
      chk("bp_vld", 32'(bus.dout_vld), 1);
      chk("bp_rdy", 32'(bus.din_rdy), 0);
    end
    rdy_hold = 1'b0; rdy_rand = 1'b0;
    wait_outs(1, 100);

    // ce low for 5 cycles mid-CALC
    hold_rst(); rel_rst();
    wait_primed(400);
    repeat (8) @(posedge clk);
    #1 bus.ce = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.ce = 1'b1;
    wait_vld(200);
    chk("ce_lat", rise_cyc - last_acc_cyc, 43);
    wait_outs(1, 100);

    // asynchronous reset in CALC at k = 10
    hold_rst(); rel_rst();
    wait_primed(400);
    repeat (11) @(negedge clk);
    chk("k10_addr", 32'(bus.rom_aa), 32'(10 << 4));
    #1 rst = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.dout_vld), 0);
    chk("arst_rdy", 32'(bus.din_rdy), 1);
    rel_rst();
    in_rand = 1'b1; rdy_rand = 1'b1;
    wait_outs(2, 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
